// File: rtl/da_wave_gen.sv
// Multi-channel DAC test-waveform generator: per-channel phase accumulators
// with sawtooth/triangle/square/DC mapping and atomically committed config.
module da_wave_gen #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ACC_W  = 24,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [1:0]               cfg_mode,
  input  logic [ACC_W-1:0]         cfg_step,
  input  logic [ACC_W-1:0]         cfg_phase,
  input  logic                     cfg_commit,
  output logic [DATA_W*NUM_CH-1:0] da_data,
  output logic                     da_valid,
  output logic [NUM_CH-1:0]        wrap
);

  // Only the top DATA_W+1 bits of the phase sum reach the mapper.
  localparam int unsigned TOP_W  = DATA_W + 1;
  localparam int unsigned TOP_SH = ACC_W - TOP_W;
  localparam logic [ACC_W-1:0] STEP_RST = ACC_W'(1) << (ACC_W - DATA_W);

  typedef enum logic [1:0] {
    MODE_SAW = 2'd0,
    MODE_TRI = 2'd1,
    MODE_SQR = 2'd2,
    MODE_DC  = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e            mode;
    logic [ACC_W-1:0] step;
    logic [ACC_W-1:0] phase;
  } cfg_t;

  // S1 carries its own mode and DC level so in-flight samples finish with
  // the config they were launched under.
  typedef struct packed {
    mode_e             mode;
    logic [TOP_W-1:0]  top;
    logic [DATA_W-1:0] level;
    logic              carry;
  } s1_t;

  localparam cfg_t CFG_RST = '{mode: MODE_SAW, step: STEP_RST, phase: '0};

  cfg_t                    shadow_q [NUM_CH];
  cfg_t                    shadow_d [NUM_CH];
  cfg_t                    active_q [NUM_CH];
  cfg_t                    active_d [NUM_CH];
  logic [ACC_W-1:0]        acc_q    [NUM_CH];
  logic [ACC_W-1:0]        acc_d    [NUM_CH];
  s1_t                     s1_q     [NUM_CH];
  s1_t                     s1_d     [NUM_CH];
  logic [NUM_CH-1:0]       carry_q, carry_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [DATA_W*NUM_CH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic [NUM_CH-1:0]       wrap_q, wrap_d;

  function automatic logic [DATA_W-1:0] map_sample(
    input mode_e             mode,
    input logic [TOP_W-1:0]  top,
    input logic [DATA_W-1:0] level
  );
    logic [DATA_W-1:0] fold;
    logic [DATA_W-1:0] res;
    fold = top[DATA_W-1:0];
    res  = '0;
    unique case (mode)
      MODE_SAW: res = top[TOP_W-1 -: DATA_W];
      MODE_TRI: res = top[TOP_W-1] ? ~fold : fold;
      MODE_SQR: res = top[TOP_W-1] ? '0 : '1;
      MODE_DC:  res = level;
    endcase
    return res;
  endfunction

  // Accumulators, config banks and the two pipeline stages; the pipeline
  // only advances on enabled cycles.
  always_comb begin
    logic [ACC_W:0] sum;
    sum        = '0;
    shadow_d   = shadow_q;
    active_d   = active_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    wrap_d     = '0;

    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      sum = {1'b0, acc_q[ch]} + {1'b0, active_q[ch].step};
      if (cfg_commit) begin
        active_d[ch] = shadow_q[ch];
        acc_d[ch]    = '0;
        carry_d[ch]  = 1'b0;
      end else if (en) begin
        acc_d[ch]   = sum[ACC_W-1:0];
        carry_d[ch] = sum[ACC_W];
      end

      if (cfg_we && (cfg_ch == CH_W'(ch))) begin
        shadow_d[ch] = '{mode: mode_e'(cfg_mode), step: cfg_step, phase: cfg_phase};
      end

      if (en) begin
        s1_d[ch].mode  = active_q[ch].mode;
        s1_d[ch].top   = TOP_W'((acc_q[ch] + active_q[ch].phase) >> TOP_SH);
        s1_d[ch].level = active_q[ch].phase[ACC_W-1 -: DATA_W];
        s1_d[ch].carry = carry_q[ch];
        if (s1_valid_q) begin
          data_d[ch*DATA_W +: DATA_W] = map_sample(s1_q[ch].mode, s1_q[ch].top, s1_q[ch].level);
          wrap_d[ch]                  = s1_q[ch].carry;
        end
      end
    end

    if (en) begin
      s1_valid_d = 1'b1;
      valid_d    = s1_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        shadow_q[ch] <= CFG_RST;
        active_q[ch] <= CFG_RST;
        acc_q[ch]    <= '0;
        s1_q[ch]     <= '0;
      end
      carry_q    <= '0;
      s1_valid_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= '0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      acc_q      <= acc_d;
      s1_q       <= s1_d;
      carry_q    <= carry_d;
      s1_valid_q <= s1_valid_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
    end
  end

  assign da_data  = data_q;
  assign da_valid = valid_q;
  assign wrap     = wrap_q;

endmodule
